apb_ucpd_tick_gen: RTL and testbench
====================================

// Module: apb_ucpd_tick_gen
// PURPOSE
//  Parametrised single-clock timing generator for the UCPD PHY. Produces one-cycle tick
//  enables (prescaled, half-bit, bit) on ic_clk instead of derived clocks, plus
//  NUM_TMR one-shot/auto-reload interval timers (interframe gap, transition window, etc.).
//  Sits between the APB register block and the BMC tx/rx engines; all consumers gate on ticks.
// PARAMETERS
//  PSC_W      3  width of psc_usbpdclk; prescale period = 2^psc ic_clk cycles
//  HDIV_W     6  width of hbitclkdiv; half-bit period = hbitclkdiv+1 prescaled ticks
//  CNT_W      5  width of each timer limit/counter
//  NUM_TMR    2  number of interval timer channels (>=1)
// PORTS
//  ic_clk        in   1                processor clock, sole clock
//  ic_rst        in   1                synchronous reset, active high
//  psc_usbpdclk  in   PSC_W            prescaler exponent (0 = bypass)
//  hbitclkdiv    in   HDIV_W           half-bit divider minus one
//  hbit_run      in   1                enable half-bit/bit tick generation (tx/rx active)
//  tmr_start     in   NUM_TMR          per-channel start/restart pulse
//  tmr_abort     in   NUM_TMR          per-channel abort pulse
//  tmr_reload    in   NUM_TMR          per-channel mode: 1 auto-reload, 0 one-shot
//  tmr_sel       in   2*NUM_TMR        per-channel tick source: 0 psc, 1 hbit, 2 bit, 3 psc
//  tmr_limit     in   CNT_W*NUM_TMR    per-channel terminal count
//  psc_tick      out  1                prescaled-clock tick
//  hbit_tick     out  1                half-bit tick
//  bit_tick      out  1                bit tick (every second hbit_tick)
//  bit_phase     out  1                0 = first half of bit, 1 = second half
//  tmr_busy      out  NUM_TMR          channel running
//  tmr_done      out  NUM_TMR          one-cycle terminal pulse
// BEHAVIOUR
//  - Single clock, synchronous active-high reset; all outputs registered, all reset to 0;
//    all counters reset to 0, all timers to IDLE.
//  - Prescaler: psc=0 -> psc_tick held 1 every cycle from first cycle after reset release.
//    psc=k>0 -> psc_cnt counts ic_clk; psc_tick high on cycles 2^k, 2*2^k, ... after reset.
//    Terminal compare is psc_cnt >= 2^k-1 so a smaller psc mid-count wraps at once, no
//    2^PSC_W overrun. 2^k computed at PSC_W+... width, no truncation at psc=max.
//  - Half-bit: hbit_run=0 -> hbit_cnt=0, bit_phase=0, no hbit/bit ticks. While hbit_run=1,
//    hbit_cnt increments on psc_tick; on psc_tick with hbit_cnt >= hbitclkdiv: hbit_cnt<=0,
//    hbit_tick pulses next cycle. hbitclkdiv=0 -> hbit_tick follows psc_tick delayed 1 cycle.
//  - Bit: each hbit_tick toggles bit_phase; bit_tick pulses with the hbit_tick that returns
//    bit_phase 1->0 (i.e. every 2nd hbit_tick after hbit_run rise). hbit_run fall clears phase.
//  - Timer FSM per channel: IDLE -> RUN on tmr_start (cnt<=0). In RUN, on selected tick:
//    cnt >= limit -> tmr_done pulse next cycle, then reload=1: cnt<=0 stay RUN; reload=0: IDLE;
//    else cnt++. Limit L -> done after L+1 source ticks; L=0 -> done on first tick.
//  - tmr_busy = (state==RUN), registered; drops in the same cycle tmr_done rises (one-shot).
//  - Precedence per channel: ic_rst > tmr_abort > tmr_start > tick. Abort: IDLE, no done.
//    Start during RUN restarts (cnt<=0); start coincident with terminal tick suppresses done.
//  - limit/sel/reload sampled live; limit lowered below cnt -> terminates on next tick.
//  - Ticks from source 1/2 never arrive while hbit_run=0; timer stays RUN (caller aborts).
//  - Reset mid-operation: everything returns to reset state next cycle, no spurious pulses.
// TESTING
//  - psc=0,hbitclkdiv=0,run=1 -> psc_tick const 1; hbit_tick every cycle; bit_tick every 2nd.
//  - psc=3,hbitclkdiv=5 -> psc_tick period 8; hbit_tick period 48; bit_tick period 96 cycles.
//  - ch0 sel=0,limit=4,psc=1,one-shot start -> tmr_done exactly once, 10 cycles after start
//    (+1 registration), busy 0 after; reload=1 -> done every 10 cycles until abort.
//  - ch1 sel=2 running, hbit_run dropped -> no done; start+abort same cycle -> stays IDLE.
//  - psc changed 7->1 with psc_cnt=100 -> psc_tick next cycle, then period 2; ic_rst mid-run
//    -> all outputs 0 next cycle, timers IDLE, no tmr_done pulse.

Source files
------------

// File: rtl/apb_ucpd_tick_gen_if.sv
// apb_ucpd_tick_gen_if: configuration, control and tick/timer status bundle of the UCPD timing generator
interface apb_ucpd_tick_gen_if #(
  parameter int PSC_W   = 3,
  parameter int HDIV_W  = 6,
  parameter int CNT_W   = 5,
  parameter int NUM_TMR = 2
);
  logic [PSC_W-1:0]         psc_usbpdclk;
  logic [HDIV_W-1:0]        hbitclkdiv;
  logic                     hbit_run;
  logic [NUM_TMR-1:0]       tmr_start;
  logic [NUM_TMR-1:0]       tmr_abort;
  logic [NUM_TMR-1:0]       tmr_reload;
  logic [2*NUM_TMR-1:0]     tmr_sel;
  logic [CNT_W*NUM_TMR-1:0] tmr_limit;
  logic                     psc_tick;
  logic                     hbit_tick;
  logic                     bit_tick;
  logic                     bit_phase;
  logic [NUM_TMR-1:0]       tmr_busy;
  logic [NUM_TMR-1:0]       tmr_done;
  modport master (
    output psc_usbpdclk, hbitclkdiv, hbit_run, tmr_start, tmr_abort, tmr_reload, tmr_sel, tmr_limit,
    input  psc_tick, hbit_tick, bit_tick, bit_phase, tmr_busy, tmr_done
  );
  modport slave (
    input  psc_usbpdclk, hbitclkdiv, hbit_run, tmr_start, tmr_abort, tmr_reload, tmr_sel, tmr_limit,
    output psc_tick, hbit_tick, bit_tick, bit_phase, tmr_busy, tmr_done
  );
endinterface

// File: rtl/apb_ucpd_tick_gen.sv
// apb_ucpd_tick_gen: single-clock prescaler, half-bit/bit tick enables and interval timers for the UCPD PHY
module apb_ucpd_tick_gen #(
  parameter int PSC_W   = 3,
  parameter int HDIV_W  = 6,
  parameter int CNT_W   = 5,
  parameter int NUM_TMR = 2
) (
  input logic                ic_clk,
  input logic                ic_rst,
  apb_ucpd_tick_gen_if.slave bus
);
  localparam int PW = 1 << PSC_W;
  localparam logic [PW:0] ONE = 1;
  typedef enum logic {IDLE, RUN} state_t;
  logic [PW-1:0]      r_psc_cnt;
  logic [HDIV_W-1:0]  r_hbit_cnt;
  logic               r_psc_tick, r_hbit_tick, r_bit_tick, r_bit_phase;
  state_t             r_state [NUM_TMR];
  logic [CNT_W-1:0]   r_cnt [NUM_TMR];
  logic [NUM_TMR-1:0] r_busy, r_done;
  logic [PW:0]        w_psc_lim;
  logic               w_psc_wrap, w_hbit_hit;
  logic [NUM_TMR-1:0] w_tick;
  logic [CNT_W-1:0]   w_limit [NUM_TMR];
  // Terminal compare is >= so shrinking the prescaler mid-count wraps immediately
  always_comb begin
    w_psc_lim  = (ONE << bus.psc_usbpdclk) - ONE;
    w_psc_wrap = {1'b0, r_psc_cnt} >= w_psc_lim;
    w_hbit_hit = bus.hbit_run && r_psc_tick && (r_hbit_cnt >= bus.hbitclkdiv);
    w_tick     = '0;
    for (int n = 0; n < NUM_TMR; n++) begin
      w_limit[n] = bus.tmr_limit[n*CNT_W +: CNT_W];
      w_tick[n]  = bus.tmr_sel[2*n +: 2] == 2'd1 ? r_hbit_tick :
                   bus.tmr_sel[2*n +: 2] == 2'd2 ? r_bit_tick : r_psc_tick;
    end
  end
  always_ff @(posedge ic_clk) begin
    if (ic_rst) begin
      r_psc_cnt   <= '0;
      r_psc_tick  <= 1'b0;
      r_hbit_cnt  <= '0;
      r_hbit_tick <= 1'b0;
      r_bit_tick  <= 1'b0;
      r_bit_phase <= 1'b0;
      r_busy      <= '0;
      r_done      <= '0;
      for (int n = 0; n < NUM_TMR; n++) begin
        r_state[n] <= IDLE;
        r_cnt[n]   <= '0;
      end
    end else begin
      r_psc_tick  <= w_psc_wrap;
      r_psc_cnt   <= w_psc_wrap ? '0 : r_psc_cnt + PW'(1);
      r_hbit_tick <= w_hbit_hit;
      r_hbit_cnt  <= !bus.hbit_run ? '0 : !r_psc_tick ? r_hbit_cnt :
                     w_hbit_hit ? '0 : r_hbit_cnt + HDIV_W'(1);
      r_bit_phase <= bus.hbit_run && (r_bit_phase ^ w_hbit_hit);
      r_bit_tick  <= w_hbit_hit && r_bit_phase;
      // Abort beats start beats tick; a start on the terminal tick swallows that done
      for (int n = 0; n < NUM_TMR; n++) begin
        r_done[n] <= 1'b0;
        if (bus.tmr_abort[n]) begin
          r_state[n] <= IDLE;
          r_busy[n]  <= 1'b0;
        end else if (bus.tmr_start[n]) begin
          r_state[n] <= RUN;
          r_busy[n]  <= 1'b1;
          r_cnt[n]   <= '0;
        end else if (r_state[n] == RUN && w_tick[n]) begin
          if (r_cnt[n] >= w_limit[n]) begin
            r_done[n] <= 1'b1;
            r_cnt[n]  <= '0;
            if (!bus.tmr_reload[n]) begin
              r_state[n] <= IDLE;
              r_busy[n]  <= 1'b0;
            end
          end else begin
            r_cnt[n] <= r_cnt[n] + CNT_W'(1);
          end
        end
      end
    end
  end
  assign bus.psc_tick  = r_psc_tick;
  assign bus.hbit_tick = r_hbit_tick;
  assign bus.bit_tick  = r_bit_tick;
  assign bus.bit_phase = r_bit_phase;
  assign bus.tmr_busy  = r_busy;
  assign bus.tmr_done  = r_done;
endmodule

// File: tb/tb_apb_ucpd_tick_gen.sv
// tb_apb_ucpd_tick_gen: vector table, directed timer/prescaler corners and a random run against an event-counting model
module tb_apb_ucpd_tick_gen;
  localparam int NT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  apb_ucpd_tick_gen_if bus ();
  apb_ucpd_tick_gen dut (.ic_clk(clk), .ic_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  // Reference model: counts elapsed cycles / source events since the last tick or start
  int   m_el = 0, m_pc = 0, m_hn = 0;
  logic m_psc = 0, m_hbit = 0, m_bit = 0, m_phase = 0;
  logic [NT-1:0] m_run = '0, m_done = '0;
  int   m_tn [NT] = '{0, 0};
  always @(posedge clk) begin
    logic p_psc, p_hbit, p_bit, src;
    if (rst) begin
      m_el = 0; m_pc = 0; m_hn = 0;
      m_psc = 0; m_hbit = 0; m_bit = 0; m_phase = 0;
      m_run = '0; m_done = '0;
      for (int n = 0; n < NT; n++) m_tn[n] = 0;
    end else begin
      p_psc = m_psc; p_hbit = m_hbit; p_bit = m_bit;
      m_el++;
      m_psc = m_el >= (1 << bus.psc_usbpdclk);
      if (m_psc) m_el = 0;
      m_hbit = 0; m_bit = 0;
      if (!bus.hbit_run) begin
        m_pc = 0; m_hn = 0;
      end else if (p_psc) begin
        m_pc++;
        if (m_pc >= int'(bus.hbitclkdiv) + 1) begin
          m_pc = 0; m_hbit = 1; m_hn++;
          m_bit = (m_hn % 2) == 0;
        end
      end
      m_phase = (m_hn % 2) == 1;
      for (int n = 0; n < NT; n++) begin
        m_done[n] = 0;
        src = bus.tmr_sel[2*n +: 2] == 2'd1 ? p_hbit : bus.tmr_sel[2*n +: 2] == 2'd2 ? p_bit : p_psc;
        if (bus.tmr_abort[n]) m_run[n] = 0;
        else if (bus.tmr_start[n]) begin
          m_run[n] = 1; m_tn[n] = 0;
        end else if (m_run[n] && src) begin
          m_tn[n]++;
          if (m_tn[n] >= int'(bus.tmr_limit[n*5 +: 5]) + 1) begin
            m_done[n] = 1; m_tn[n] = 0;
            if (!bus.tmr_reload[n]) m_run[n] = 0;
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("m_psc_tick", bus.psc_tick, m_psc);
    chk("m_hbit_tick", bus.hbit_tick, m_hbit);
    chk("m_bit_tick", bus.bit_tick, m_bit);
    chk("m_bit_phase", bus.bit_phase, m_phase);
    chk("m_busy", bus.tmr_busy, m_run);
    chk("m_done", bus.tmr_done, m_done);
  end
  task automatic reset_cfg(input int psc, input int div, input bit run);
    @(negedge clk);
    rst = 1;
    bus.psc_usbpdclk = 3'(psc); bus.hbitclkdiv = 6'(div); bus.hbit_run = run;
    bus.tmr_start = '0; bus.tmr_abort = '0; bus.tmr_reload = '0; bus.tmr_sel = '0; bus.tmr_limit = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.psc_tick, bus.hbit_tick, bus.bit_tick, bus.bit_phase, bus.tmr_busy, bus.tmr_done}, 0);
    rst = 0;
  endtask
  typedef struct {int psc; int div; bit run; int n; int e_psc; int e_hbit; int e_bit;} vec_t;
  vec_t vec [5];
  initial begin
    int cp, ch, cb, dc, dk, b10, b11;
    bus.psc_usbpdclk = '0; bus.hbitclkdiv = '0; bus.hbit_run = 0;
    bus.tmr_start = '0; bus.tmr_abort = '0; bus.tmr_reload = '0; bus.tmr_sel = '0; bus.tmr_limit = '0;
    vec[0] = '{0, 0, 1, 200, 200, 199, 99};
    vec[1] = '{3, 5, 1, 960, 120, 19, 9};
    vec[2] = '{1, 2, 1, 120, 60, 19, 9};
    vec[3] = '{7, 0, 1, 600, 4, 4, 2};
    vec[4] = '{2, 1, 0, 100, 25, 0, 0};
    for (int i = 0; i < 5; i++) begin
      reset_cfg(vec[i].psc, vec[i].div, vec[i].run);
      cp = 0; ch = 0; cb = 0;
      for (int k = 0; k < vec[i].n; k++) begin
        @(negedge clk);
        cp += int'(bus.psc_tick); ch += int'(bus.hbit_tick); cb += int'(bus.bit_tick);
      end
      chk($sformatf("vec%0d_psc", i), cp, vec[i].e_psc);
      chk($sformatf("vec%0d_hbit", i), ch, vec[i].e_hbit);
      chk($sformatf("vec%0d_bit", i), cb, vec[i].e_bit);
    end
    // One-shot, limit 4 on a /2 prescaler: done 10 cycles after the start edge
    reset_cfg(1, 0, 0);
    bus.tmr_limit[4:0] = 5'd4; bus.tmr_start[0] = 1;
    dc = 0; dk = 0; b10 = 0; b11 = 1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) bus.tmr_start[0] = 0;
      if (bus.tmr_done[0]) begin dc++; dk = k; end
      if (k == 10) b10 = int'(bus.tmr_busy[0]);
      if (k == 11) b11 = int'(bus.tmr_busy[0]);
    end
    chk("oneshot_done_count", dc, 1);
    chk("oneshot_done_cycle", dk, 11);
    chk("oneshot_busy_before", b10, 1);
    chk("oneshot_busy_after", b11, 0);
    // Auto-reload every 10 cycles until abort
    reset_cfg(1, 0, 0);
    bus.tmr_limit[4:0] = 5'd4; bus.tmr_reload[0] = 1; bus.tmr_start[0] = 1;
    dc = 0; dk = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 1) bus.tmr_start[0] = 0;
      if (k == 35) bus.tmr_abort[0] = 1;
      if (k == 36) bus.tmr_abort[0] = 0;
      if (bus.tmr_done[0]) begin dc++; dk = k; end
    end
    chk("reload_done_count", dc, 3);
    chk("reload_last_done", dk, 31);
    chk("reload_busy_after_abort", int'(bus.tmr_busy[0]), 0);
    // Bit-tick timer stalls when hbit_run drops; start+abort together stays idle
    reset_cfg(0, 1, 1);
    bus.tmr_sel[3:2] = 2'd2; bus.tmr_limit[9:5] = 5'd31; bus.tmr_start[1] = 1;
    @(negedge clk);
    bus.tmr_start[1] = 0;
    repeat (20) @(negedge clk);
    bus.hbit_run = 0;
    dc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      dc += int'(bus.tmr_done[1]);
    end
    chk("stall_no_done", dc, 0);
    chk("stall_busy", int'(bus.tmr_busy[1]), 1);
    bus.tmr_abort[1] = 1;
    @(negedge clk);
    bus.tmr_abort[1] = 0;
    chk("stall_abort_busy", int'(bus.tmr_busy[1]), 0);
    bus.tmr_start[1] = 1; bus.tmr_abort[1] = 1;
    @(negedge clk);
    bus.tmr_start[1] = 0; bus.tmr_abort[1] = 0;
    chk("start_abort_busy", int'(bus.tmr_busy[1]), 0);
    // Prescaler shrunk from 7 to 1 while count is 100
    reset_cfg(7, 0, 0);
    repeat (100) @(negedge clk);
    bus.psc_usbpdclk = 3'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("psc_shrink_%0d", k), int'(bus.psc_tick), (k % 2) == 0 ? 1 : 0);
    end
    // Reset in the cycle before a reload done would fire
    reset_cfg(0, 0, 1);
    bus.tmr_limit[4:0] = 5'd3; bus.tmr_reload[0] = 1; bus.tmr_start[0] = 1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.tmr_start[0] = 0;
    end
    rst = 1;
    @(negedge clk);
    chk("rst_mid_outputs", {bus.psc_tick, bus.hbit_tick, bus.bit_tick, bus.bit_phase, bus.tmr_busy, bus.tmr_done}, 0);
    rst = 0;
    dc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dc += int'(bus.tmr_done[0]) + int'(bus.tmr_busy[0]);
    end
    chk("rst_mid_timer_idle", dc, 0);
    // Random phase, checked by the model every cycle
    reset_cfg(0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 49) == 0) bus.psc_usbpdclk = $urandom_range(0, 9) == 0 ? 3'd7 : 3'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) bus.hbitclkdiv = 6'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) bus.hbit_run = ~bus.hbit_run;
      if ($urandom_range(0, 29) == 0) bus.tmr_sel = 4'($urandom);
      if ($urandom_range(0, 29) == 0) bus.tmr_limit = 10'($urandom_range(0, 1023) & 10'h0E7);
      if ($urandom_range(0, 29) == 0) bus.tmr_reload = 2'($urandom);
      for (int n = 0; n < NT; n++) begin
        bus.tmr_start[n] = $urandom_range(0, 24) == 0;
        bus.tmr_abort[n] = $urandom_range(0, 59) == 0;
      end
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
